// File: rtl/img_proc_pkg.sv
// img_proc_pkg: coefficients, counter width and shared types for the plate-localisation image stages.
package img_proc_pkg;
  localparam int PIX_CNT_W = 12;
  localparam logic [7:0] Y_KR  = 8'd77;
  localparam logic [7:0] Y_KG  = 8'd150;
  localparam logic [7:0] Y_KB  = 8'd29;
  localparam logic [7:0] CB_KR = 8'd43;
  localparam logic [7:0] CB_KG = 8'd85;
  localparam logic [7:0] CB_KB = 8'd128;
  localparam logic [7:0] CR_KR = 8'd128;
  localparam logic [7:0] CR_KG = 8'd107;
  localparam logic [7:0] CR_KB = 8'd21;
  localparam logic [15:0] CHROMA_OFS = 16'd32768;
  typedef logic [PIX_CNT_W-1:0] pix_cnt_t;
  typedef struct packed {
    logic vsync;
    logic href;
    logic de;
  } sync_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;
  // replicate the MSBs so full-scale 565 maps to 255
  function automatic rgb888_t rgb565_to_888(input logic [15:0] p);
    return '{r: {p[15:11], p[15:13]}, g: {p[10:5], p[10:9]}, b: {p[4:0], p[4:2]}};
  endfunction
endpackage

// File: rtl/cmos_rgb2ycbcr_if.sv
// cmos_rgb2ycbcr_if: capture-side RGB565 stream in, YCbCr stream with coordinates out.
interface cmos_rgb2ycbcr_if;
  import img_proc_pkg::*;
  logic pre_frame_vsync;
  logic pre_frame_href;
  logic pre_frame_de;
  logic [15:0] pre_rgb565;
  logic post_frame_vsync;
  logic post_frame_href;
  logic post_frame_de;
  logic [7:0] post_img_y;
  logic [7:0] post_img_cb;
  logic [7:0] post_img_cr;
  pix_cnt_t post_pix_x;
  pix_cnt_t post_pix_y;
  logic post_frame_done;
  pix_cnt_t lines_last;
  modport master (
    output pre_frame_vsync, pre_frame_href, pre_frame_de, pre_rgb565,
    input  post_frame_vsync, post_frame_href, post_frame_de, post_img_y, post_img_cb, post_img_cr,
    input  post_pix_x, post_pix_y, post_frame_done, lines_last
  );
  modport slave (
    input  pre_frame_vsync, pre_frame_href, pre_frame_de, pre_rgb565,
    output post_frame_vsync, post_frame_href, post_frame_de, post_img_y, post_img_cb, post_img_cr,
    output post_pix_x, post_pix_y, post_frame_done, lines_last
  );
endinterface

// File: rtl/img_pix_coord.sv
// img_pix_coord: x/y pixel coordinates, frame-done pulse and per-frame line tally from a sync stream.
module img_pix_coord
  import img_proc_pkg::*;
#(
  parameter pix_cnt_t H_DISP = 12'd640,
  parameter pix_cnt_t V_DISP = 12'd480
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     vsync,
  input  logic     href,
  input  logic     de,
  output pix_cnt_t pix_x,
  output pix_cnt_t pix_y,
  output logic     frame_done,
  output pix_cnt_t lines_last
);
  logic href_d, vsync_d, href_fall, vs_rise;
  pix_cnt_t x_cnt, y_cnt, line_cnt;
  assign href_fall = href_d & ~href;
  assign vs_rise = vsync & ~vsync_d;
  assign frame_done = vs_rise;
  assign pix_x = x_cnt;
  assign pix_y = y_cnt;
  // clears win over increments so a frame boundary never leaks a stale count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      href_d <= 1'b0;
      vsync_d <= 1'b0;
      x_cnt <= '0;
      y_cnt <= '0;
      line_cnt <= '0;
      lines_last <= '0;
    end else begin
      href_d <= href;
      vsync_d <= vsync;
      x_cnt <= href_fall ? '0 : (de && x_cnt != H_DISP - pix_cnt_t'(1)) ? x_cnt + pix_cnt_t'(1) : x_cnt;
      y_cnt <= vs_rise ? '0 : (href_fall && y_cnt != V_DISP - pix_cnt_t'(1)) ? y_cnt + pix_cnt_t'(1) : y_cnt;
      line_cnt <= vs_rise ? '0 : href_fall ? line_cnt + pix_cnt_t'(1) : line_cnt;
      lines_last <= vs_rise ? line_cnt + pix_cnt_t'(href_fall) : lines_last;
    end
  end
endmodule

// File: rtl/cmos_rgb2ycbcr.sv
// cmos_rgb2ycbcr: 3-stage RGB565 to YCbCr 4:4:4 converter with aligned syncs and pixel coordinates.
module cmos_rgb2ycbcr
  import img_proc_pkg::*;
#(
  parameter pix_cnt_t H_DISP = 12'd640,
  parameter pix_cnt_t V_DISP = 12'd480
) (
  input logic cam_pclk,
  input logic rst,
  cmos_rgb2ycbcr_if.slave bus
);
  rgb888_t px;
  logic [15:0] p_yr, p_yg, p_yb, p_cbr, p_cbg, p_cbb, p_crr, p_crg, p_crb;
  logic [15:0] sum_y, sum_cb, sum_cr;
  logic [7:0] img_y, img_cb, img_cr;
  sync_t [2:0] sd;
  assign px = rgb565_to_888(bus.pre_rgb565);
  // offset-plus-positive term first keeps the 16-bit chroma sums from wrapping
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      {p_yr, p_yg, p_yb, p_cbr, p_cbg, p_cbb, p_crr, p_crg, p_crb} <= '0;
      {sum_y, sum_cb, sum_cr} <= '0;
      {img_y, img_cb, img_cr} <= '0;
      sd <= '0;
    end else begin
      p_yr <= 16'(px.r) * 16'(Y_KR);
      p_yg <= 16'(px.g) * 16'(Y_KG);
      p_yb <= 16'(px.b) * 16'(Y_KB);
      p_cbr <= 16'(px.r) * 16'(CB_KR);
      p_cbg <= 16'(px.g) * 16'(CB_KG);
      p_cbb <= 16'(px.b) * 16'(CB_KB);
      p_crr <= 16'(px.r) * 16'(CR_KR);
      p_crg <= 16'(px.g) * 16'(CR_KG);
      p_crb <= 16'(px.b) * 16'(CR_KB);
      sum_y <= p_yr + p_yg + p_yb;
      sum_cb <= (CHROMA_OFS + p_cbb) - (p_cbr + p_cbg);
      sum_cr <= (CHROMA_OFS + p_crr) - (p_crg + p_crb);
      img_y <= sum_y[15:8];
      img_cb <= sum_cb[15:8];
      img_cr <= sum_cr[15:8];
      sd <= {sd[1:0], sync_t'{vsync: bus.pre_frame_vsync, href: bus.pre_frame_href, de: bus.pre_frame_de}};
    end
  end
  assign bus.post_frame_vsync = sd[2].vsync;
  assign bus.post_frame_href = sd[2].href;
  assign bus.post_frame_de = sd[2].de;
  assign bus.post_img_y = img_y;
  assign bus.post_img_cb = img_cb;
  assign bus.post_img_cr = img_cr;
  img_pix_coord #(.H_DISP(H_DISP), .V_DISP(V_DISP)) u_coord (
    .clk(cam_pclk),
    .rst(rst),
    .vsync(sd[2].vsync),
    .href(sd[2].href),
    .de(sd[2].de),
    .pix_x(bus.post_pix_x),
    .pix_y(bus.post_pix_y),
    .frame_done(bus.post_frame_done),
    .lines_last(bus.lines_last)
  );
endmodule

// File: tb/tb_cmos_rgb2ycbcr.sv
// tb_cmos_rgb2ycbcr: directed vectors for colour conversion, sync latency, coordinates, saturation and reset.
module tb_cmos_rgb2ycbcr;
  import img_proc_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cmos_rgb2ycbcr_if bus();
  cmos_rgb2ycbcr dut (.cam_pclk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  bit coord_on = 1'b0;
  logic [23:0] q[$];
  logic [15:0] cv [5] = '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0, 16'h001F};
  logic [7:0] e_y [5] = '{8'd255, 8'd0, 8'd76, 8'd149, 8'd28};
  logic [7:0] e_cb [5] = '{8'd128, 8'd128, 8'd85, 8'd43, 8'd255};
  logic [7:0] e_cr [5] = '{8'd128, 8'd128, 8'd255, 8'd21, 8'd107};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic h, input logic d, input logic [15:0] p, input int ex, input int ey);
    logic [23:0] e;
    bus.pre_frame_vsync = v;
    bus.pre_frame_href = h;
    bus.pre_frame_de = d;
    bus.pre_rgb565 = p;
    if (d && coord_on) q.push_back({12'(ey), 12'(ex)});
    @(posedge clk);
    #1;
    if (bus.post_frame_done) n_done++;
    if (coord_on && bus.post_frame_de) begin
      if (q.size() == 0) chk("de_unexpected", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("pix_x", 32'(bus.post_pix_x), 32'(e[11:0]));
        chk("pix_y", 32'(bus.post_pix_y), 32'(e[23:12]));
      end
    end
  endtask
  task automatic idle(input int n, input logic v);
    for (int i = 0; i < n; i++) cyc(v, 1'b0, 1'b0, 16'h0, 0, 0);
  endtask
  task automatic zero_chk(input string tag);
    chk({tag, "_y"}, 32'(bus.post_img_y), 32'd0);
    chk({tag, "_cb"}, 32'(bus.post_img_cb), 32'd0);
    chk({tag, "_cr"}, 32'(bus.post_img_cr), 32'd0);
    chk({tag, "_sync"}, 32'({bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_de}), 32'd0);
    chk({tag, "_pix_x"}, 32'(bus.post_pix_x), 32'd0);
    chk({tag, "_pix_y"}, 32'(bus.post_pix_y), 32'd0);
    chk({tag, "_lines_last"}, 32'(bus.lines_last), 32'd0);
    chk({tag, "_done"}, 32'(bus.post_frame_done), 32'd0);
  endtask
  initial begin
    logic [2:0] h0, h1, cur;
    bus.pre_frame_vsync = 1'b0;
    bus.pre_frame_href = 1'b0;
    bus.pre_frame_de = 1'b0;
    bus.pre_rgb565 = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    zero_chk("reset");
    rst = 1'b0;
    coord_on = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 1'b1, cv[k], k, 0);
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 0, 0);
      chk("de_early", 32'(bus.post_frame_de), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 0, 0);
      chk("de_lat3", 32'(bus.post_frame_de), 32'd1);
      chk("y", 32'(bus.post_img_y), 32'(e_y[k]));
      chk("cb", 32'(bus.post_img_cb), 32'(e_cb[k]));
      chk("cr", 32'(bus.post_img_cr), 32'(e_cr[k]));
    end
    idle(3, 1'b0);
    chk("colour_q_empty", 32'(q.size()), 32'd0);
    coord_on = 1'b0;
    h0 = 3'b0;
    h1 = 3'b0;
    for (int i = 0; i < 10000; i++) begin
      cur = 3'($urandom_range(0, 7));
      bus.pre_frame_vsync = cur[2];
      bus.pre_frame_href = cur[1];
      bus.pre_frame_de = cur[0];
      bus.pre_rgb565 = 16'($urandom);
      @(posedge clk);
      #1;
      chk("sync_delay3", 32'({bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_de}), 32'(h1));
      h1 = h0;
      h0 = cur;
    end
    idle(4, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    coord_on = 1'b1;
    idle(2, 1'b1);
    idle(4, 1'b0);
    n_done = 0;
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 640; i++) cyc(1'b0, 1'b1, 1'b1, 16'(i), i, l);
      idle(3, 1'b0);
    end
    idle(2, 1'b0);
    idle(5, 1'b1);
    chk("frame_done_once", 32'(n_done), 32'd1);
    chk("lines_last_4", 32'(bus.lines_last), 32'd4);
    chk("y_cleared", 32'(bus.post_pix_y), 32'd0);
    idle(2, 1'b0);
    for (int i = 0; i < 700; i++) cyc(1'b0, 1'b1, 1'b1, 16'hF800, (i < 639) ? i : 639, 0);
    idle(4, 1'b0);
    chk("x_clear_after_line", 32'(bus.post_pix_x), 32'd0);
    chk("y_after_line", 32'(bus.post_pix_y), 32'd1);
    idle(2, 1'b1);
    idle(4, 1'b0);
    for (int l = 0; l < 500; l++) begin
      cyc(1'b0, 1'b1, 1'b1, 16'h001F, 0, (l < 479) ? l : 479);
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 0, 0);
    end
    idle(4, 1'b0);
    chk("y_sat", 32'(bus.post_pix_y), 32'd479);
    idle(2, 1'b1);
    idle(4, 1'b0);
    chk("lines_last_500", 32'(bus.lines_last), 32'd500);
    cyc(1'b0, 1'b1, 1'b1, 16'hFFFF, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, 16'hFFFF, 1, 0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, 16'hFFFF, 0, 1);
    n_done = 0;
    idle(5, 1'b1);
    chk("coincide_done", 32'(n_done), 32'd1);
    chk("coincide_y_clear", 32'(bus.post_pix_y), 32'd0);
    chk("coincide_lines_last", 32'(bus.lines_last), 32'd2);
    idle(2, 1'b0);
    for (int i = 0; i < 203; i++) cyc(1'b0, 1'b1, 1'b1, 16'hFFFF, i, 0);
    chk("midline_x200", 32'(bus.post_pix_x), 32'd200);
    chk("midline_y_pre", 32'(bus.post_img_y), 32'd255);
    q.delete();
    rst = 1'b1;
    #1;
    zero_chk("midline_rst");
    bus.pre_frame_href = 1'b0;
    bus.pre_frame_de = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2, 1'b1);
    idle(4, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 16'h07E0, i, 0);
    idle(4, 1'b0);
    chk("restart_q_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
